// File: rtl/tracked_stack.sv
// Shift-register stack with registered outputs and optional sticky error flags.
// Define TRACKED_STACK_ERROR_FLAGS_EN to build the overflow/underflow flag registers.
module tracked_stack #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int VISIBLES = 2,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             push,
    input  logic                             pop,
    input  logic [WIDTH-1:0]                 insert,
    input  logic                             err_clear,
    output logic [VISIBLES-1:0][WIDTH-1:0]   tops,
    output logic [VISIBLES-1:0]              tops_valid,
    output logic [CW-1:0]                    count,
    output logic                             empty,
    output logic                             full,
    output logic                             overflow,
    output logic                             underflow
);

    logic [WIDTH-1:0] mem [DEPTH];

    logic do_push;
    logic do_pop;
    logic do_repl;
    logic ovf_evt;
    logic udf_evt;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // Push+pop on an empty stack degenerates to a plain push.
    always_comb begin
        do_push = push & (~pop | empty);
        do_pop  = pop & ~push & ~empty;
        do_repl = push & pop & ~empty;
        ovf_evt = push & ~pop & full;
        udf_evt = pop & ~push & empty;
    end

    // Storage shifts as a whole; vacated slots are zero-filled so unused entries read 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            count <= '0;
        end else if (do_push) begin
            mem[0] <= insert;
            for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
            if (!full) count <= count + 1'b1;
        end else if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
            mem[DEPTH-1] <= '0;
            count <= count - 1'b1;
        end else if (do_repl) begin
            mem[0] <= insert;
        end
    end

    // Expose the top entries and their occupancy.
    always_comb begin
        for (int i = 0; i < VISIBLES; i++) begin
            tops[i]       = mem[i];
            tops_valid[i] = (32'(count) > i);
        end
    end

`ifdef TRACKED_STACK_ERROR_FLAGS_EN
    // Sticky flags; a new event outranks a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_evt)        overflow  <= 1'b1;
            else if (err_clear) overflow  <= 1'b0;
            if (udf_evt)        underflow <= 1'b1;
            else if (err_clear) underflow <= 1'b0;
        end
    end
`else
    logic unused_err;
    assign unused_err = err_clear ^ ovf_evt ^ udf_evt;
    assign overflow   = 1'b0;
    assign underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_tracked_stack.sv
// Directed bench for tracked_stack (WIDTH=8, DEPTH=4, VISIBLES=2).
// Flag expectations follow whether TRACKED_STACK_ERROR_FLAGS_EN is defined.
module tb_tracked_stack;

`ifdef TRACKED_STACK_ERROR_FLAGS_EN
    localparam logic EF = 1'b1;
`else
    localparam logic EF = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            push = 1'b0;
    logic            pop = 1'b0;
    logic [7:0]      insert = 8'h00;
    logic            err_clear = 1'b0;
    logic [1:0][7:0] tops;
    logic [1:0]      tops_valid;
    logic [2:0]      count;
    logic            empty;
    logic            full;
    logic            overflow;
    logic            underflow;

    int tests = 0;
    int fails = 0;

    tracked_stack #(.WIDTH(8), .DEPTH(4), .VISIBLES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .insert     (insert),
        .err_clear  (err_clear),
        .tops       (tops),
        .tops_valid (tops_valid),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic p, input logic q, input logic [7:0] d,
                      input logic clr);
        push = p;
        pop = q;
        insert = d;
        err_clear = clr;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop = 1'b0;
        err_clear = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_tv", 32'(tops_valid), 0);
        chk("rst_tops", 32'(tops), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_udf", 32'(underflow), 0);
        reset = 1'b0;

        op(1, 0, 8'h11, 0);
        chk("p1_top0", 32'(tops[0]), 32'h11);
        chk("p1_count", 32'(count), 1);
        op(1, 0, 8'h22, 0);
        op(1, 0, 8'h33, 0);
        chk("p3_top0", 32'(tops[0]), 32'h33);
        chk("p3_top1", 32'(tops[1]), 32'h22);
        chk("p3_count", 32'(count), 3);
        chk("p3_tv", 32'(tops_valid), 3);
        chk("p3_empty", 32'(empty), 0);
        chk("p3_full", 32'(full), 0);

        op(1, 0, 8'h44, 0);
        chk("p4_full", 32'(full), 1);
        chk("p4_count", 32'(count), 4);
        chk("p4_ovf", 32'(overflow), 0);
        op(1, 0, 8'h55, 0);
        chk("ovf_count", 32'(count), 4);
        chk("ovf_flag", 32'(overflow), 32'(EF));
        chk("ovf_top0", 32'(tops[0]), 32'h55);
        chk("ovf_top1", 32'(tops[1]), 32'h44);

        op(1, 1, 8'h99, 0);
        chk("pp_top0", 32'(tops[0]), 32'h99);
        chk("pp_top1", 32'(tops[1]), 32'h44);
        chk("pp_count", 32'(count), 4);
        chk("pp_udf", 32'(underflow), 0);

        op(0, 1, 8'h00, 0);
        chk("pop1_top0", 32'(tops[0]), 32'h44);
        chk("pop1_top1", 32'(tops[1]), 32'h33);
        op(0, 1, 8'h00, 0);
        op(0, 1, 8'h00, 0);
        chk("pop3_top0", 32'(tops[0]), 32'h22);
        chk("pop3_top1", 32'(tops[1]), 32'h00);
        chk("pop3_tv", 32'(tops_valid), 1);
        op(0, 1, 8'h00, 0);
        chk("pop4_count", 32'(count), 0);
        chk("pop4_empty", 32'(empty), 1);
        chk("pop4_tops", 32'(tops), 0);
        chk("pop4_udf", 32'(underflow), 0);
        op(0, 1, 8'h00, 0);
        chk("pop5_count", 32'(count), 0);
        chk("pop5_udf", 32'(underflow), 32'(EF));

        op(0, 0, 8'h00, 1);
        chk("clr_udf", 32'(underflow), 0);
        chk("clr_ovf", 32'(overflow), 0);

        op(0, 1, 8'h00, 1);
        chk("clr_vs_evt", 32'(underflow), 32'(EF));
        op(0, 0, 8'h00, 0);
        chk("udf_hold", 32'(underflow), 32'(EF));
        op(0, 0, 8'h00, 1);
        chk("clr2_udf", 32'(underflow), 0);

        op(1, 1, 8'h7E, 0);
        chk("ppe_count", 32'(count), 1);
        chk("ppe_top0", 32'(tops[0]), 32'h7E);
        chk("ppe_tv", 32'(tops_valid), 1);
        chk("ppe_udf", 32'(underflow), 0);

        op(1, 0, 8'hA1, 0);
        op(1, 0, 8'hA2, 0);
        op(1, 0, 8'hA3, 0);
        op(1, 0, 8'hA4, 0);
        op(0, 1, 8'h00, 0);
        chk("pre_count", 32'(count), 3);
        chk("pre_ovf", 32'(overflow), 32'(EF));
        chk("pre_top0", 32'(tops[0]), 32'hA3);

        #2;
        push = 1'b1;
        insert = 8'hEE;
        reset = 1'b1;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_ovf", 32'(overflow), 0);
        chk("arst_tops", 32'(tops), 0);
        @(posedge clk);
        #1;
        chk("arst_abort", 32'(count), 0);
        push = 1'b0;
        reset = 1'b0;

        op(1, 0, 8'hA5, 0);
        chk("post_count", 32'(count), 1);
        chk("post_top0", 32'(tops[0]), 32'hA5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
